// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin front end that lets NREQ requesters share
// one external param_adder. One operand pair is in flight at a time: it is
// captured on grant, held on the adder inputs, and its sum/carry are
// registered and returned on a single response channel tagged with the
// requester ID.
module adder_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             ready_en;
  logic [IDW-1:0]   next_ptr;

  // The adder only ever sees the captured operands, so its inputs are
  // registered and quiet (zero) out of reset.
  assign add_a = op_a;
  assign add_b = op_b;
  assign busy  = (state != IDLE);

  // A grant is offered only while idle; rst_n also gates it so the ready
  // bits are zero for the whole reset pulse even if requesters are active.
  assign ready_en = rst_n && (state == IDLE) && grant_found;

  // The served requester becomes lowest priority: next search starts after it.
  assign next_ptr = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;

  // Round-robin search: first valid requester starting from rr_ptr, wrapping
  // modulo NREQ. Scanning offsets high-to-low lets the smallest offset win.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // One-hot ready decode of the granted index.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = ready_en && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Transaction sequencer: capture on grant, register the adder result,
  // then hold the response until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            op_b   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
            rsp_id <= grant_idx;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_carry <= add_carry;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter (WIDTH=8, NREQ=4) with a behavioural
// stand-in for the external param_adder.
module tb_adder_share_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_carry;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int mdl_ptr = 0;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  // External adder model
  assign {add_carry, add_sum} = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first pending requester at or after the pointer, wrapping.
  function automatic int mdl_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // One full transaction from the current IDLE cycle, with bp cycles of
  // response backpressure. Optionally the granted requester drops its valid.
  task automatic run_txn(input int bp, input bit drop, output int g);
    int ea, eb, full;
    g = mdl_grant(req_valid, mdl_ptr);
    if (g < 0) begin
      chk("no_pending_request", 32'(req_valid), 32'hF);
      return;
    end
    ea   = int'(req_a[g*WIDTH +: WIDTH]);
    eb   = int'(req_b[g*WIDTH +: WIDTH]);
    full = ea + eb;
    chk("grant_ready", 32'(req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    step();
    if (drop) req_valid[g] = 1'b0;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_ready", 32'(req_ready), 0);
    chk("exec_rsp_valid", 32'(rsp_valid), 0);
    chk("exec_add_a", 32'(add_a), 32'(ea));
    chk("exec_add_b", 32'(add_b), 32'(eb));
    step();
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_sum", 32'(rsp_sum), 32'(full % 256));
    chk("rsp_carry", 32'(rsp_carry), 32'(full / 256));
    for (int c = 0; c < bp; c++) begin
      rsp_ready = 1'b0;
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_id", 32'(rsp_id), 32'(g));
      chk("bp_rsp_sum", 32'(rsp_sum), 32'(full % 256));
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 0);
    chk("done_busy", 32'(busy), 0);
    mdl_ptr = (g + 1) % NREQ;
    $display("txn: id=%0d a=%02h b=%02h sum=%02h carry=%0d bp=%0d", g, ea, eb,
             full % 256, full / 256, bp);
  endtask

  initial begin
    int g;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    // Reset state
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_sum", 32'(rsp_sum), 0);
    chk("rst_rsp_carry", 32'(rsp_carry), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_add_b", 32'(add_b), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single request
    set_op(0, 8'h05, 8'h03);
    req_valid = 4'b0001;
    #1;
    run_txn(0, 1, g);

    // Overflow cases on requester 2
    set_op(2, 8'hFF, 8'hFF);
    req_valid = 4'b0100;
    #1;
    run_txn(0, 1, g);
    set_op(2, 8'h80, 8'h80);
    req_valid = 4'b0100;
    #1;
    run_txn(0, 1, g);

    // Round-robin from a fresh reset: all four pending
    rst_n = 1'b0;
    #1;
    mdl_ptr = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 8'h10);
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) run_txn(0, 0, g);
    req_valid = '0;

    // Backpressure
    set_op(1, 8'h21, 8'h42);
    req_valid = 4'b0010;
    #1;
    run_txn(5, 1, g);

    // Reset while requester 3 is executing
    set_op(3, 8'h33, 8'h44);
    req_valid = 4'b1000;
    #1;
    g = mdl_grant(req_valid, mdl_ptr);
    chk("rst_mid_grant", 32'(req_ready), 32'(1 << g));
    step();
    req_valid = '0;
    chk("rst_mid_exec_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mid_rsp_id", 32'(rsp_id), 0);
    chk("rst_mid_rsp_sum", 32'(rsp_sum), 0);
    chk("rst_mid_add_a", 32'(add_a), 0);
    chk("rst_mid_add_b", 32'(add_b), 0);
    set_op(0, 8'h0A, 8'h0B);
    req_valid = 4'b1001;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 0);
    step();
    step();
    chk("rst_hold_rsp_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    mdl_ptr = 0;
    #1;
    run_txn(0, 1, g);
    run_txn(0, 1, g);

    // Idle with stray rsp_ready
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_ready", 32'(req_ready), 0);
      chk("idle_busy_q", 32'(busy), 0);
      chk("idle_valid_q", 32'(rsp_valid), 0);
    end
    rsp_ready = 1'b0;

    // Zero operands
    set_op(2, 0, 0);
    req_valid = 4'b0100;
    #1;
    run_txn(0, 1, g);

    // Randomized traffic with protocol-respecting requesters
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
    req_valid = 4'($urandom_range(1, 15));
    #1;
    for (int t = 0; t < 40; t++) begin
      run_txn(int'($urandom_range(0, 2)), 1, g);
      if (g >= 0) set_op(g, $urandom, $urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom % 2 == 1)) begin
          set_op(i, $urandom, $urandom);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) req_valid[$urandom % NREQ] = 1'b1;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
